// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounces the Mode/Inc keys and sequences the clock's
// time-setting mode (RUN -> SET_MIN -> SET_HOUR -> SET_WEEK -> RUN), issuing
// single-cycle adjust pulses with auto-repeat plus blink and seconds-hold controls.
module time_set_ctrl #(
    parameter int DB_CYCLES      = 1_000_000,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int RPT_CYCLES     = 5_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int BLINK_CYCLES   = 12_500_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KeyMode_n,
    input  logic       KeyInc_n,
    output logic       AdjtMin,
    output logic       AdjtHour,
    output logic       AdjtWeek,
    output logic [1:0] SetMode,
    output logic       Blink,
    output logic       SecHold
);

    localparam int DB_W    = $clog2(DB_CYCLES) + 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam int RPT_W   = $clog2(RPT_CYCLES) + 1;
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int BLINK_W = $clog2(BLINK_CYCLES) + 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_ONE     = DB_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [RPT_W-1:0]   RPT_LAST   = RPT_W'(RPT_CYCLES - 1);
    localparam logic [RPT_W-1:0]   RPT_ONE    = RPT_W'(1);
    localparam logic [TO_W-1:0]    TO_MAX     = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]    TO_ONE     = TO_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    // Key vector index: bit 0 = Mode, bit 1 = Inc.
    localparam int K_MODE = 0;
    localparam int K_INC  = 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MIN  = 2'd1,
        ST_HOUR = 2'd2,
        ST_WEEK = 2'd3
    } state_t;

    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            deb_prev_q, deb_prev_d;
    logic [1:0]            armed_q, armed_d;
    logic [1:0]            press_q, press_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [RPT_W-1:0]      rpt_cnt_q, rpt_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  blink_q, blink_d;
    logic                  adjt_min_q, adjt_min_d;
    logic                  adjt_hour_q, adjt_hour_d;
    logic                  adjt_week_q, adjt_week_d;
    logic                  sechold_q, sechold_d;

    logic                  inc_evt_s;
    logic                  stay_set_s;
    logic                  rpt_fire_s;
    logic                  adjt_s;

    function automatic state_t next_mode(input state_t s);
        case (s)
            ST_RUN:  next_mode = ST_MIN;
            ST_MIN:  next_mode = ST_HOUR;
            ST_HOUR: next_mode = ST_WEEK;
            ST_WEEK: next_mode = ST_RUN;
            default: next_mode = ST_RUN;
        endcase
    endfunction

    // Synchronize, debounce and edge-detect both keys.
    // Synchronizers leave reset at 0 and a key only becomes "armed" once a real
    // released level has been seen, so a key held through reset gives no press.
    always_comb begin
        sync1_d    = {KeyInc_n, KeyMode_n};
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        db_cnt_d   = db_cnt_q;
        armed_d    = armed_q;
        press_d    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] != deb_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    deb_d[k]    = sync2_q[k];
                    db_cnt_d[k] = '0;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_ONE;
                end
            end else begin
                db_cnt_d[k] = '0;
            end
            armed_d[k] = armed_q[k] | (sync2_q[k] & deb_q[k]);
            press_d[k] = deb_prev_q[k] & ~deb_q[k] & armed_q[k];
        end
    end

    // Mode FSM next state, timeout, auto-repeat, adjust pulses and blink.
    always_comb begin
        inc_evt_s = press_q[K_INC] & ~press_q[K_MODE] & (state_q != ST_RUN);

        if (press_q[K_MODE]) begin
            state_d = next_mode(state_q);
        end else if ((state_q != ST_RUN) && (to_cnt_q == TO_MAX)) begin
            state_d = ST_RUN;
        end else begin
            state_d = state_q;
        end

        // True only while remaining in the same SET state this cycle.
        stay_set_s = (state_d == state_q) && (state_q != ST_RUN);

        // Inactivity timeout: only press events restart it, never a held key.
        if (!stay_set_s || (press_q != 2'b00)) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_ONE;
        end else begin
            to_cnt_d = to_cnt_q;
        end

        // Auto-repeat: hold counter saturates at HOLD, then the repeat counter
        // fires on every wrap through zero.
        hold_cnt_d = hold_cnt_q;
        rpt_cnt_d  = rpt_cnt_q;
        rpt_fire_s = 1'b0;
        if (!stay_set_s || deb_q[K_INC]) begin
            hold_cnt_d = '0;
            rpt_cnt_d  = '0;
        end else if (inc_evt_s) begin
            hold_cnt_d = HOLD_ONE;
            rpt_cnt_d  = '0;
        end else if (hold_cnt_q == HOLD_MAX) begin
            rpt_fire_s = (rpt_cnt_q == '0);
            rpt_cnt_d  = (rpt_cnt_q == RPT_LAST) ? '0 : (rpt_cnt_q + RPT_ONE);
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end

        adjt_s      = (inc_evt_s | rpt_fire_s) & stay_set_s;
        adjt_min_d  = 1'b0;
        adjt_hour_d = 1'b0;
        adjt_week_d = 1'b0;
        case (state_q)
            ST_MIN:  adjt_min_d  = adjt_s;
            ST_HOUR: adjt_hour_d = adjt_s;
            ST_WEEK: adjt_week_d = adjt_s;
            default: begin
                adjt_min_d  = 1'b0;
                adjt_hour_d = 1'b0;
                adjt_week_d = 1'b0;
            end
        endcase

        // Blink restarts low on any state change or edit so the field shows.
        if (!stay_set_s || adjt_s) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q + BLINK_ONE;
        end

        sechold_d = (state_d != ST_RUN);
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            deb_q       <= 2'b11;
            deb_prev_q  <= 2'b11;
            armed_q     <= 2'b00;
            press_q     <= 2'b00;
            db_cnt_q    <= '0;
            state_q     <= ST_RUN;
            hold_cnt_q  <= '0;
            rpt_cnt_q   <= '0;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            adjt_min_q  <= 1'b0;
            adjt_hour_q <= 1'b0;
            adjt_week_q <= 1'b0;
            sechold_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            armed_q     <= armed_d;
            press_q     <= press_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            to_cnt_q    <= to_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            adjt_min_q  <= adjt_min_d;
            adjt_hour_q <= adjt_hour_d;
            adjt_week_q <= adjt_week_d;
            sechold_q   <= sechold_d;
        end
    end

    assign AdjtMin  = adjt_min_q;
    assign AdjtHour = adjt_hour_q;
    assign AdjtWeek = adjt_week_q;
    assign SetMode  = state_q;
    assign Blink    = blink_q;
    assign SecHold  = sechold_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with small timing parameters
// (DB=4 HOLD=20 RPT=5 TIMEOUT=100 BLINK=8). A raw key fall sampled at edge t
// shows its effect on the outputs at edge t+7.
module tb_time_set_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       KeyMode_n;
    logic       KeyInc_n;
    logic       AdjtMin;
    logic       AdjtHour;
    logic       AdjtWeek;
    logic [1:0] SetMode;
    logic       Blink;
    logic       SecHold;

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;

    time_set_ctrl #(
        .DB_CYCLES     (4),
        .HOLD_CYCLES   (20),
        .RPT_CYCLES    (5),
        .TIMEOUT_CYCLES(100),
        .BLINK_CYCLES  (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .KeyMode_n(KeyMode_n),
        .KeyInc_n (KeyInc_n),
        .AdjtMin  (AdjtMin),
        .AdjtHour (AdjtHour),
        .AdjtWeek (AdjtWeek),
        .SetMode  (SetMode),
        .Blink    (Blink),
        .SecHold  (SecHold)
    );

    always #5 CLK = ~CLK;

    // Count rising edges; at a negedge cyc equals the number of edges so far.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic until_cyc(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    // Press one key low for 'low' cycles, release, then let everything settle.
    task automatic press(input bit inc, input int low);
        if (inc) KeyInc_n = 1'b0;
        else     KeyMode_n = 1'b0;
        tick(low);
        if (inc) KeyInc_n = 1'b1;
        else     KeyMode_n = 1'b1;
        tick(14);
    endtask

    initial begin
        int c;
        int f;
        int e;
        int d;
        int npulse;
        int other;
        logic exp_h;

        RST       = 1'b1;
        KeyMode_n = 1'b1;
        KeyInc_n  = 1'b1;
        tick(3);
        check("rst_setmode", SetMode, 2'd0);
        check("rst_adjt", {AdjtMin, AdjtHour, AdjtWeek}, 3'b000);
        check("rst_blink_sechold", {Blink, SecHold}, 2'b00);
        RST = 1'b0;
        tick(10);

        // 1: clean Mode press, exact latency, then three more presses.
        c = cyc;
        KeyMode_n = 1'b0;
        tick(6);
        KeyMode_n = 1'b1;
        until_cyc(c + 7);
        check("t1_before", SetMode, 2'd0);
        until_cyc(c + 8);
        check("t1_setmode", SetMode, 2'd1);
        check("t1_sechold", SecHold, 1'b1);
        tick(12);
        press(1'b0, 6);
        check("t1_hour", SetMode, 2'd2);
        press(1'b0, 6);
        check("t1_week", SetMode, 2'd3);
        press(1'b0, 6);
        check("t1_wrap", SetMode, 2'd0);
        check("t1_run_sechold", SecHold, 1'b0);
        check("t1_run_blink", Blink, 1'b0);

        // 2: 3-cycle glitches are rejected; a 5-cycle low advances once.
        for (int i = 0; i < 3; i++) begin
            KeyMode_n = 1'b0;
            tick(3);
            KeyMode_n = 1'b1;
            tick(3);
        end
        tick(12);
        check("t2_glitch", SetMode, 2'd0);
        press(1'b0, 5);
        check("t2_5cyc", SetMode, 2'd1);
        tick(5);
        check("t2_once", SetMode, 2'd1);

        // 3: held Inc in SET_HOUR auto-repeats at +0,+20,+25..+45.
        press(1'b0, 6);
        check("t3_hour", SetMode, 2'd2);
        c = cyc;
        f = c + 8;
        npulse = 0;
        other  = 0;
        KeyInc_n = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            tick(1);
            if (cyc == f + 41) KeyInc_n = 1'b1;
            d = cyc - f;
            exp_h = (d == 0) || ((d >= 20) && (d <= 45) && ((d % 5) == 0));
            check("t3_adjthour", AdjtHour, exp_h);
            if (AdjtHour) npulse++;
            if (AdjtMin || AdjtWeek) other++;
        end
        check("t3_count", npulse, 7);
        check("t3_other", other, 0);
        check("t3_state", SetMode, 2'd2);

        // 4: timeout from SET_MIN, blink phase, and postponement by a press.
        press(1'b0, 6);
        check("t4_week", SetMode, 2'd3);
        press(1'b0, 6);
        check("t4_run", SetMode, 2'd0);
        c = cyc;
        e = c + 8;
        KeyMode_n = 1'b0;
        tick(6);
        KeyMode_n = 1'b1;
        until_cyc(e + 7);
        check("t4_blink_lo", Blink, 1'b0);
        until_cyc(e + 8);
        check("t4_blink_hi", Blink, 1'b1);
        until_cyc(e + 100);
        check("t4_pre_to", SetMode, 2'd1);
        check("t4_pre_sechold", SecHold, 1'b1);
        until_cyc(e + 101);
        check("t4_to_mode", SetMode, 2'd0);
        check("t4_to_blink", Blink, 1'b0);
        check("t4_to_sechold", SecHold, 1'b0);
        tick(5);

        c = cyc;
        e = c + 8;
        KeyMode_n = 1'b0;
        tick(6);
        KeyMode_n = 1'b1;
        until_cyc(e + 58);
        KeyInc_n = 1'b0;
        until_cyc(e + 64);
        KeyInc_n = 1'b1;
        until_cyc(e + 65);
        check("t4b_min_pre", AdjtMin, 1'b0);
        until_cyc(e + 66);
        check("t4b_min_pulse", AdjtMin, 1'b1);
        until_cyc(e + 67);
        check("t4b_min_post", AdjtMin, 1'b0);
        until_cyc(e + 101);
        check("t4b_postponed", SetMode, 2'd1);
        until_cyc(e + 166);
        check("t4b_still_set", SetMode, 2'd1);
        until_cyc(e + 167);
        check("t4b_to", SetMode, 2'd0);
        tick(5);

        // 5: simultaneous Mode+Inc -> Mode wins; Inc in RUN is ignored.
        press(1'b0, 6);
        check("t5_min", SetMode, 2'd1);
        npulse = 0;
        KeyMode_n = 1'b0;
        KeyInc_n  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i == 6) begin
                KeyMode_n = 1'b1;
                KeyInc_n  = 1'b1;
            end
            if (AdjtMin || AdjtHour || AdjtWeek) npulse++;
        end
        check("t5_no_adjt", npulse, 0);
        check("t5_mode_wins", SetMode, 2'd2);
        press(1'b0, 6);
        press(1'b0, 6);
        check("t5_run", SetMode, 2'd0);
        npulse = 0;
        KeyInc_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i == 6) KeyInc_n = 1'b1;
            if (AdjtMin || AdjtHour || AdjtWeek) npulse++;
        end
        check("t5_run_inc", npulse, 0);
        check("t5_run_state", SetMode, 2'd0);

        // 6: reset during auto-repeat in SET_WEEK; held Inc gives nothing after.
        press(1'b0, 6);
        press(1'b0, 6);
        press(1'b0, 6);
        check("t6_week", SetMode, 2'd3);
        c = cyc;
        f = c + 8;
        KeyInc_n = 1'b0;
        until_cyc(f);
        check("t6_first", AdjtWeek, 1'b1);
        until_cyc(f + 20);
        check("t6_repeat", AdjtWeek, 1'b1);
        until_cyc(f + 22);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check("t6_rst_mode", SetMode, 2'd0);
        check("t6_rst_outs", {AdjtMin, AdjtHour, AdjtWeek, Blink, SecHold}, 5'b00000);
        npulse = 0;
        other  = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (AdjtMin || AdjtHour || AdjtWeek) npulse++;
            if (SetMode != 2'd0) other++;
        end
        check("t6_held_no_adjt", npulse, 0);
        check("t6_held_run", other, 0);
        KeyInc_n = 1'b1;
        tick(15);
        press(1'b0, 6);
        press(1'b0, 6);
        press(1'b0, 6);
        check("t6_week_again", SetMode, 2'd3);
        c = cyc;
        KeyInc_n = 1'b0;
        tick(6);
        KeyInc_n = 1'b1;
        until_cyc(c + 7);
        check("t6_repress_pre", AdjtWeek, 1'b0);
        until_cyc(c + 8);
        check("t6_repress", AdjtWeek, 1'b1);
        until_cyc(c + 9);
        check("t6_repress_post", AdjtWeek, 1'b0);
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
